ram_port_master: RTL and testbench

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_port_pkg.sv | 17 +
 rtl/ram_port_rsp_fifo.sv | 53 +++++
 rtl/ram_port_master.sv | 132 +++++++++++++
 tb/tb_ram_port_master.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_pkg.sv
// Shared defaults and the request record used by the RAM port master and its users.
package ram_port_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 3;
  localparam int DEF_READ_LATENCY  = 1;
  localparam int DEF_WRITE_LATENCY = 1;
  localparam int DEF_RSP_DEPTH     = 4;

  // One request as offered on the request channel (default widths).
  typedef struct packed {
    logic                         we;
    logic [DEF_ADDRESS_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]    wdata;
  } req_t;

endpackage

// File: rtl/ram_port_rsp_fifo.sv
// Response FIFO: holds captured read data until the consumer takes it.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module ram_port_rsp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int            IW      = $clog2(DEPTH);
  localparam logic [IW:0]   PTR_ONE = (IW+1)'(1);

  logic [IW:0]           wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  full;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                   (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

  // Advance write/read pointers on push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Store pushed data.
  // NOTE: storage is not reset; only the pointers decide what is valid, and a reset array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[IW-1:0]] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !pop_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && empty_o));

endmodule

// File: rtl/ram_port_master.sv
// Request-channel to RAM-port bridge: issues reads/writes to a fixed-latency
// RAM, stalls reads on response credit and read-after-write hazards, and
// returns read data in issue order through a response FIFO.
module ram_port_master
  import ram_port_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter int RSP_DEPTH     = DEF_RSP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam int             CW     = $clog2(RSP_DEPTH) + 1;
  localparam int             OW     = CW + 1;
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic                    fire, rd_fire, wr_fire;
  logic                    capture, pop, hazard, credit_ok;
  logic [READ_LATENCY-1:0] rd_pipe_q;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_head;

  // Reads may only issue while every outstanding read still has a FIFO slot.
  assign credit_ok = (OW'(inflight_q) + OW'(fifo_count)) < OW'(RSP_DEPTH);
  // Ready is gated by rst_n directly so it drops the instant reset asserts.
  assign req_ready = rst_n && (req_we || (credit_ok && !hazard));
  assign fire      = req_valid && req_ready;
  assign rd_fire   = fire && !req_we;
  assign wr_fire   = fire && req_we;

  assign ram_en   = fire;
  assign ram_we   = wr_fire;
  assign ram_addr = fire ? req_addr  : '0;
  assign ram_din  = fire ? req_wdata : '0;

  assign capture   = rd_pipe_q[READ_LATENCY-1];
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_head : '0;

  // Shift a valid bit per issued read; it reaches the last stage when ram_dout holds its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  // Next in-flight count: +1 on read issue, -1 on capture, hold when both or neither.
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    inflight_d = inflight_q;
    if (rd_fire && !capture)      inflight_d = inflight_q + CNT_ONE;
    else if (!rd_fire && capture) inflight_d = inflight_q - CNT_ONE;
  end

  // Register the in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  a_inflight_range: assert property (@(posedge clk) disable iff (!rst_n)
    OW'(inflight_q) <= OW'(RSP_DEPTH));

  // Writes not yet committed block reads to the same address.
  if (WRITE_LATENCY > 1) begin : g_wr_track
    localparam int WD = WRITE_LATENCY - 1;
    logic [WD-1:0]            wr_vld_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q [WD];

    // Record {valid, addr} of each issued write for the commit window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_vld_q <= '0;
        for (int i = 0; i < WD; i++) wr_addr_q[i] <= '0;
      end else begin
        wr_vld_q[0]  <= wr_fire;
        wr_addr_q[0] <= req_addr;
        for (int i = 1; i < WD; i++) begin
          wr_vld_q[i]  <= wr_vld_q[i-1];
          wr_addr_q[i] <= wr_addr_q[i-1];
        end
      end
    end

    // Flag a hazard when any pending write targets the offered address.
    always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < WD; i++)
        if (wr_vld_q[i] && (wr_addr_q[i] == req_addr)) hazard = 1'b1;
    end
  end else begin : g_no_wr_track
    assign hazard = 1'b0;
  end

  ram_port_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture),
    .push_data_i (ram_dout),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master with READ_LATENCY=3, WRITE_LATENCY=3, RSP_DEPTH=4.
// A timed RAM model drives ram_dout; an in-order program model predicts
// every response and the read-acceptance rule.
module tb_ram_port_master;
  import ram_port_pkg::*;

  localparam int DW = 8, AW = 3, RL = 3, WL = 3, DEPTH = 4;
  localparam int NA = 1 << AW;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  ram_port_master #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL),
    .WRITE_LATENCY(WL), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] ram_mem   [NA];
  logic [DW-1:0] model_mem [NA];
  int            last_wr   [NA];
  logic [DW-1:0] exp_q [$];
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_rdata;

  always @(posedge clk) cyc++;

  // ---------------- timed RAM model ----------------
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } pend_t;
  pend_t wr_pend [$];
  pend_t rd_pend [$];
  int    edge_n = 0;
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;

  always @(negedge clk) begin
    s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_din = ram_din;
  end

  always @(posedge clk) begin : ram_model
    pend_t p;
    if (s_en && s_we) begin
      p.due = edge_n + WL - 1; p.addr = s_addr; p.data = s_din;
      wr_pend.push_back(p);
    end
    while (wr_pend.size() > 0 && wr_pend[0].due == edge_n) begin
      ram_mem[wr_pend[0].addr] = wr_pend[0].data;
      void'(wr_pend.pop_front());
    end
    if (s_en && !s_we) begin
      p.due = edge_n + RL - 1; p.addr = s_addr; p.data = ram_mem[s_addr];
      rd_pend.push_back(p);
    end
    while (rd_pend.size() > 0 && rd_pend[0].due == edge_n) begin
      ram_dout <= rd_pend[0].data;
      void'(rd_pend.pop_front());
    end
    edge_n++;
  end

  // ---------------- program-order model and monitor ----------------
  always @(negedge clk) begin : monitor
    logic hz, exp_rdy, fire;
    if (!rst_n) begin
      vectors++;
      if ({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h en=%b we=%b a=%h din=%h, want all 0",
                 req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din);
      end
      exp_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
      for (int a = 0; a < NA; a++) last_wr[a] = -1000;
    end else begin
      hz      = (cyc - last_wr[req_addr]) <= (WL - 1);
      exp_rdy = req_we || ((outstanding < DEPTH) && !hz);
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL req_ready cyc=%0d we=%b addr=%0d: got %b want %b", cyc, req_we, req_addr,
                 req_ready, exp_rdy);
      end
      fire = req_valid && req_ready;
      vectors++;
      if ({ram_en, ram_we, ram_addr, ram_din} !==
          (fire ? {1'b1, req_we, req_addr, req_wdata} : '0)) begin
        miscompares++;
        $display("FAIL ram_port cyc=%0d fire=%b: got en=%b we=%b a=%h din=%h", cyc, fire,
                 ram_en, ram_we, ram_addr, ram_din);
      end
      if (rsp_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_spurious cyc=%0d: got rsp_valid=1 data=%h, want no response", cyc, rsp_rdata);
        end else if (rsp_rdata !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rsp_data cyc=%0d: got %h want %h", cyc, rsp_rdata, exp_q[0]);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (!rsp_valid || rsp_rdata !== prev_rdata) begin
          miscompares++;
          $display("FAIL rsp_hold cyc=%0d: got v=%b d=%h want v=1 d=%h", cyc, rsp_valid, rsp_rdata, prev_rdata);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      if (fire && req_we) begin
        model_mem[req_addr] = req_wdata;
        last_wr[req_addr]   = cyc;
      end
      if (fire && !req_we) begin
        exp_q.push_back(model_mem[req_addr]);
        outstanding++;
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        outstanding--;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Offer one request until it fires; returns the cycle it fired in, -1 on timeout.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int fire_cyc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    fire_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        fire_cyc = cyc;
        break;
      end
      tick();
    end
    tick();
    req_valid = 1'b0;
    vectors++;
    if (fire_cyc < 0) begin
      miscompares++;
      $display("FAIL issue_timeout we=%b addr=%0d: got no accept, want accept within 50 cycles", we, a);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) break;
      tick();
    end
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d responses missing, want 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got outputs nonzero, want all 0");
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got %b want 1", req_ready);
    end
    @(negedge clk);
    tick();
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_read_latency();
    int fc;
    rsp_ready = 1'b1;
    issue(1'b1, 3'd2, 8'h5A, fc);
    idle(WL);
    issue(1'b0, 3'd2, 8'h00, fc);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== (k == 4)) begin
        miscompares++;
        $display("FAIL read_latency t+%0d: got rsp_valid=%b want %b", k, rsp_valid, (k == 4));
      end
      if (k == 4) begin
        vectors++;
        if (rsp_rdata !== 8'h5A) begin
          miscompares++;
          $display("FAIL read_latency_data: got %h want 5a", rsp_rdata);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_write_hazard();
    int  fc;
    bit  seen;
    rsp_ready = 1'b1;
    issue(1'b1, 3'd4, 8'h11, fc);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd4;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== (k == 3)) begin
        miscompares++;
        $display("FAIL hazard_stall t+%0d: got req_ready=%b want %b", k, req_ready, (k == 3));
      end
      tick();
    end
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        vectors++;
        if (rsp_rdata !== 8'h11) begin
          miscompares++;
          $display("FAIL hazard_data: got %h want 11", rsp_rdata);
        end
      end
      tick();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL hazard_timeout: got no response, want data 11");
    end
    drain();
  endtask

  task automatic test_credit();
    logic [DW-1:0] want [6];
    logic [DW-1:0] got  [$];
    int nxt, fires;
    for (int i = 0; i < 6; i++) want[i] = model_mem[i];
    rsp_ready = 1'b0;
    nxt = 0; fires = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_addr = AW'(nxt);
      @(negedge clk);
      if (req_ready) begin fires++; nxt++; end
      tick();
    end
    vectors++;
    if (fires != 4) begin
      miscompares++;
      $display("FAIL credit_fires: got %0d reads accepted want 4", fires);
    end
    req_addr = AW'(nxt);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_stall: got req_ready=%b want 0", req_ready);
    end
    req_we = 1'b1; req_addr = 3'd7; req_wdata = 8'hC3;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_write: got req_ready=%b want 1", req_ready);
    end
    tick();
    req_we = 1'b0; req_addr = AW'(nxt); rsp_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
      if (req_valid && req_ready) nxt++;
      tick();
      if (nxt >= 6) req_valid = 1'b0;
      else          req_addr = AW'(nxt);
    end
    req_valid = 1'b0;
    vectors++;
    if (got.size() != 6) begin
      miscompares++;
      $display("FAIL credit_count: got %0d responses want 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL credit_order[%0d]: got %h want %h", i, got[i], want[i]);
      end
    end
    drain();
  endtask

  task automatic test_random();
    req_t r;
    int   n;
    bit   done_req;
    n = 0; done_req = 1'b1;
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      if (done_req) begin
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = AW'($urandom);
        r.wdata = DW'($urandom);
        req_valid = ($urandom_range(0, 3) != 0);
        req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (req_valid && req_ready) n++;
      done_req = !req_valid || req_ready;
      tick();
    end
    req_valid = 1'b0;
    vectors++;
    if (n != 1000) begin
      miscompares++;
      $display("FAIL random_count: got %0d requests accepted want 1000", n);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_addr = AW'(c);
      tick();
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got outputs nonzero, want all 0");
    end
    repeat (5) tick();
    req_valid = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_capture k=%0d: got rsp_valid=1 want 0", k);
      end
      tick();
    end
    begin
      int fc;
      issue(1'b0, 3'd5, 8'h00, fc);
    end
    drain();
  endtask

  initial begin
    for (int a = 0; a < NA; a++) begin
      ram_mem[a]   = DW'($urandom);
      model_mem[a] = ram_mem[a];
      last_wr[a]   = -1000;
    end
    ram_dout  = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_read_latency();
    test_write_hazard();
    test_credit();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
